// File: rtl/branch_exec_unit.sv
// rtl/branch_exec_unit.sv - branch/jump resolve stage with output FIFO and optional perf counters
// Optional feature macro: BRU_PERF_CNT_EN (perf_branches / perf_mispredicts).
module branch_exec_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_cmpop,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pc_pred,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_rd_data,
    output logic [XLEN-1:0]  out_pc_next,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispredicts
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JAL    = 2'b01;
    localparam logic [1:0] KIND_JALR   = 2'b10;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  rd_data;
        logic [XLEN-1:0]  pc_next;
        logic             taken;
        logic             mispredict;
        logic             legal;
    } entry_t;

    logic            cond_taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] jalr_target;
    entry_t          c_entry;

    always_comb begin
        cond_taken = 1'b0;
        case (in_cmpop)
            3'b000:  cond_taken = (in_rs1 == in_rs2);
            3'b001:  cond_taken = (in_rs1 != in_rs2);
            3'b100:  cond_taken = ($signed(in_rs1) <  $signed(in_rs2));
            3'b101:  cond_taken = ($signed(in_rs1) >= $signed(in_rs2));
            3'b110:  cond_taken = (in_rs1 <  in_rs2);
            3'b111:  cond_taken = (in_rs1 >= in_rs2);
            default: cond_taken = 1'b0;
        endcase
    end

    assign pc_plus4    = in_pc + XLEN'(4);
    assign pc_target   = in_pc + in_imm;
    assign jalr_target = (in_rs1 + in_imm) & ~XLEN'(1);

    always_comb begin
        c_entry     = '0;
        c_entry.tag = in_tag;
        case (in_kind)
            KIND_BRANCH: begin
                c_entry.taken   = cond_taken;
                c_entry.pc_next = cond_taken ? pc_target : pc_plus4;
                c_entry.rd_data = '0;
                c_entry.legal   = 1'b1;
            end
            KIND_JAL: begin
                c_entry.taken   = 1'b1;
                c_entry.pc_next = pc_target;
                c_entry.rd_data = pc_plus4;
                c_entry.legal   = 1'b1;
            end
            KIND_JALR: begin
                c_entry.taken   = 1'b1;
                c_entry.pc_next = jalr_target;
                c_entry.rd_data = pc_plus4;
                c_entry.legal   = 1'b1;
            end
            default: begin
                c_entry.taken   = 1'b0;
                c_entry.pc_next = pc_plus4;
                c_entry.rd_data = '0;
                c_entry.legal   = 1'b0;
            end
        endcase
        c_entry.mispredict = (c_entry.pc_next != in_pc_pred);
    end

    logic             s1_valid;
    entry_t           s1_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];
    entry_t           head;
    logic             accept;
    logic             push;
    logic             pop;

    // Counting S1 as occupied guarantees its unconditional push always has room.
    assign in_ready  = (count + CNT_W'(s1_valid)) < CNT_W'(DEPTH);
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid && !flush;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
        if (accept) begin
            s1_entry <= c_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s1_entry;
        end
    end

    assign out_tag        = out_valid ? head.tag        : '0;
    assign out_rd_data    = out_valid ? head.rd_data    : '0;
    assign out_pc_next    = out_valid ? head.pc_next    : '0;
    assign out_taken      = out_valid ? head.taken      : 1'b0;
    assign out_mispredict = out_valid ? head.mispredict : 1'b0;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mis_q;

    // Counters survive flush so they reflect every result that actually left the unit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else if (pop) begin
            if (head.legal) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (head.mispredict) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`else
    logic unused_head_legal;
    assign unused_head_legal = head.legal;
    assign perf_branches     = '0;
    assign perf_mispredicts  = '0;
`endif

endmodule

// File: tb/tb_branch_exec_unit.sv
// tb/tb_branch_exec_unit.sv - directed table-driven bench for branch_exec_unit
module tb_branch_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [2:0]  in_cmpop;
    logic [31:0] in_pc, in_pc_pred, in_imm, in_rs1, in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_tag;
    logic [31:0] out_rd_data, out_pc_next;
    logic        out_taken, out_mispredict;
    logic [31:0] perf_branches, perf_mispredicts;

    always #5 clk = ~clk;

    branch_exec_unit #(.XLEN(32), .TAG_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_cmpop(in_cmpop), .in_pc(in_pc), .in_pc_pred(in_pc_pred),
        .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_rd_data(out_rd_data), .out_pc_next(out_pc_next),
        .out_taken(out_taken), .out_mispredict(out_mispredict),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  cmpop;
        logic [31:0] pc;
        logic [31:0] pred;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  tag;
        logic [31:0] exp_rd;
        logic [31:0] exp_next;
        logic        exp_taken;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [12];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] kind, input logic [2:0] cmpop,
                            input logic [31:0] pc, input logic [31:0] pred,
                            input logic [31:0] imm, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [4:0] tag);
        in_valid   = 1'b1;
        in_kind    = kind;
        in_cmpop   = cmpop;
        in_pc      = pc;
        in_pc_pred = pred;
        in_imm     = imm;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_tag     = tag;
    endtask

    initial begin
        logic [31:0] exp_br;
        logic [31:0] exp_mis;
        logic [4:0]  exp_q [$];
        logic [4:0]  next_tag;
        int          accepted;
        int          got;
        int          seen;

        vecs[0]  = '{2'b00, 3'b000, 32'h1000, 32'h1004, 32'h20, 32'd5, 32'd5, 5'd1, 32'h0, 32'h1020, 1'b1, 1'b1};
        vecs[1]  = '{2'b00, 3'b100, 32'h2000, 32'h2004, 32'h40, 32'hFFFFFFFF, 32'd1, 5'd2, 32'h0, 32'h2040, 1'b1, 1'b1};
        vecs[2]  = '{2'b00, 3'b110, 32'h2000, 32'h2004, 32'h40, 32'hFFFFFFFF, 32'd1, 5'd3, 32'h0, 32'h2004, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 3'b000, 32'h400, 32'h3004, 32'h2, 32'h3003, 32'd0, 5'd4, 32'h404, 32'h3004, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 3'b000, 32'h100, 32'hF0, 32'hFFFFFFF0, 32'd0, 32'd0, 5'd5, 32'h104, 32'hF0, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 3'b001, 32'h500, 32'h508, 32'h8, 32'd3, 32'd3, 5'd6, 32'h0, 32'h504, 1'b0, 1'b1};
        vecs[6]  = '{2'b00, 3'b101, 32'h600, 32'h610, 32'h10, 32'd1, 32'hFFFFFFFF, 5'd7, 32'h0, 32'h610, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 3'b111, 32'h700, 32'h704, 32'h10, 32'd1, 32'hFFFFFFFF, 5'd8, 32'h0, 32'h704, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 3'b010, 32'h800, 32'h810, 32'h10, 32'd0, 32'd0, 5'd9, 32'h0, 32'h804, 1'b0, 1'b1};
        vecs[9]  = '{2'b11, 3'b000, 32'h900, 32'h904, 32'h20, 32'h1000, 32'd0, 5'd10, 32'h0, 32'h904, 1'b0, 1'b0};
        vecs[10] = '{2'b01, 3'b000, 32'hFFFFFFFC, 32'h4, 32'h8, 32'd0, 32'd0, 5'd11, 32'h0, 32'h4, 1'b1, 1'b0};
        vecs[11] = '{2'b00, 3'b000, 32'hFFFFFFFC, 32'h0, 32'h8, 32'd7, 32'd8, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive_op(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        in_valid = 1'b0;
        step();
        step();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_pc_next", 64'(out_pc_next), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset perf_branches", 64'(perf_branches), 64'd0);
        rst_n = 1'b1;
        step();

        exp_br = 0;
        exp_mis = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_op(vecs[i].kind, vecs[i].cmpop, vecs[i].pc, vecs[i].pred,
                     vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].tag);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d not yet visible", i), 64'(out_valid), 64'd0);
            step();
            check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("v%0d tag", i), 64'(out_tag), 64'(vecs[i].tag));
            check($sformatf("v%0d pc_next", i), 64'(out_pc_next), 64'(vecs[i].exp_next));
            check($sformatf("v%0d rd_data", i), 64'(out_rd_data), 64'(vecs[i].exp_rd));
            check($sformatf("v%0d taken", i), 64'(out_taken), 64'(vecs[i].exp_taken));
            check($sformatf("v%0d mispredict", i), 64'(out_mispredict), 64'(vecs[i].exp_mis));
            if (vecs[i].kind != 2'b11) exp_br = exp_br + 1;
            if (vecs[i].exp_mis) exp_mis = exp_mis + 1;
            step();
            check($sformatf("v%0d drained", i), 64'(out_valid), 64'd0);
        end
`ifndef BRU_PERF_CNT_EN
        exp_br = 0;
        exp_mis = 0;
`endif
        check("perf_branches after table", 64'(perf_branches), 64'(exp_br));
        check("perf_mispredicts after table", 64'(perf_mispredicts), 64'(exp_mis));

        // Back-pressure: with out_ready low, exactly DEPTH ops fit.
        out_ready = 1'b0;
        next_tag = 5'd16;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            drive_op(2'b01, 3'b000, 32'h100 * c, 32'h0, 32'h40, 32'h0, 32'h0, next_tag);
            if (in_ready) begin
                exp_q.push_back(next_tag);
                next_tag = next_tag + 5'd1;
                accepted++;
            end
            step();
        end
        in_valid = 1'b0;
        check("bp accepted count", 64'(accepted), 64'd4);
        check("bp in_ready low when full", 64'(in_ready), 64'd0);
        check("bp out_valid when full", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp extra result", 64'(out_tag), 64'h3F);
                end else begin
                    check($sformatf("bp order %0d", got), 64'(out_tag), 64'(exp_q.pop_front()));
                end
                got++;
            end
            step();
        end
        check("bp results drained", 64'(got), 64'd4);

        // Flush with 3 ops in flight and a new op offered on the flush edge.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_op(2'b00, 3'b000, 32'h40, 32'h44, 32'h8, 32'd1, 32'd1, 5'(10 + c));
            step();
        end
        check("pre-flush out_valid", 64'(out_valid), 64'd1);
        drive_op(2'b01, 3'b000, 32'h80, 32'h0, 32'h4, 32'h0, 32'h0, 5'd13);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("flushed results leaked", 64'(seen), 64'd0);
        drive_op(2'b01, 3'b000, 32'h1000, 32'h1010, 32'h10, 32'h0, 32'h0, 5'd20);
        step();
        in_valid = 1'b0;
        step();
        check("post-flush tag", 64'(out_tag), 64'd20);
        check("post-flush rd_data", 64'(out_rd_data), 64'h1004);
        step();

        // Reset mid-operation discards everything and clears the counters.
        out_ready = 1'b0;
        drive_op(2'b00, 3'b000, 32'h40, 32'h0, 32'h8, 32'd1, 32'd1, 5'd1);
        step();
        drive_op(2'b00, 3'b000, 32'h40, 32'h0, 32'h8, 32'd1, 32'd1, 5'd2);
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid-reset out_valid", 64'(out_valid), 64'd0);
        check("mid-reset in_ready", 64'(in_ready), 64'd1);
        check("mid-reset perf_branches", 64'(perf_branches), 64'd0);
        check("mid-reset perf_mispredicts", 64'(perf_mispredicts), 64'd0);
        step();
        step();
        check("mid-reset stays empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_exec_unit.md
Name: branch_exec_unit

Overview:
- Pipelined, parametrised branch/jump execution unit for the out-of-order core.
- Sits between the branch reservation station and the CDB arbiter.
- Resolves conditional branches, JAL and JALR, computes link value and actual next PC, and flags mispredicts against the predicted PC.
- Results are buffered in an output FIFO so CDB back-pressure never stalls resolution; a flush discards all in-flight work.

Parameters:
- XLEN, 32, datapath width for PC, operands and results.
- TAG_W, 5, width of the ROB tag carried with each op.
- DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush; drops all in-flight and buffered ops.
- in_valid  in  1  op presented by the reservation station.
- in_ready  out  1  unit can accept an op this cycle.
- in_kind  in  2  operation kind: 00 = cond branch, 01 = JAL, 10 = JALR, 11 = illegal.
- in_cmpop  in  3  RV32 branch funct3.
- in_pc  in  XLEN  PC of the op.
- in_pc_pred  in  XLEN  predicted next PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1, in_rs2  in  XLEN  operand values.
- in_tag  in  TAG_W  ROB tag.
- out_valid  out  1  result available.
- out_ready  in  1  CDB accepts the result.
- out_tag  out  TAG_W  ROB tag of the result.
- out_rd_data  out  XLEN  link value.
- out_pc_next  out  XLEN  resolved next PC.
- out_taken  out  1  branch or jump taken.
- out_mispredict  out  1  out_pc_next differs from the predicted PC.
- perf_branches, perf_mispredicts  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Handshake: an op is accepted on any clock edge where in_valid and in_ready are both high. A result leaves on any edge where out_valid and out_ready are both high. Payload is held stable while valid is high and ready is low.
- Stage S1 is a registered compute stage holding the resolved result, its tag and s1_valid.
  - Each cycle, S1 pushes into the FIFO if s1_valid is high.
  - in_ready = (fifo_count + s1_valid) < DEPTH, so a push into the FIFO never overflows it.
- Latency: an op accepted at edge N is in S1 after N; it is in the FIFO and visible on out_* after edge N+1. With out_ready held high, throughput is 1 op per cycle.
- Compare, signed or unsigned per funct3:
  - beq: equal.
  - bne: not equal.
  - blt: signed less-than.
  - bge: signed greater-or-equal.
  - bltu: unsigned less-than.
  - bgeu: unsigned greater-or-equal.
  - funct3 010 or 011: not taken.
- Cond branch:
  - taken: pc_next = pc + imm.
  - not taken: pc_next = pc + 4.
  - rd_data = 0.
- JAL: taken = 1, pc_next = pc + imm, rd_data = pc + 4.
- JALR: taken = 1, pc_next = (rs1 + imm) with bit 0 cleared, rd_data = pc + 4.
- Illegal kind: taken = 0, pc_next = pc + 4, rd_data = 0, mispredict computed normally.
- Arithmetic is modulo 2^XLEN; wrap-around is silently ignored.
- mispredict = (pc_next != pc_pred), evaluated for every kind.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle when full is legal: count is unchanged.
  - Pop when empty is impossible, because out_valid = (count != 0).
- Flush has priority over everything:
  - On an edge where flush is high, s1_valid, the FIFO count and the pointers clear.
  - Any op handshaked in that cycle is discarded.
  - out_valid is low the cycle after the edge.
  - Flush and in_valid asserted together: the op is dropped.
- Reset: while rst_n is low at an edge, all state clears: s1_valid = 0, count = 0, pointers = 0, counters = 0.
  - After reset: out_valid = 0, out_* payload = 0, in_ready = 1.
  - Reset mid-operation discards everything.
- out_* payload is 0 when out_valid is low.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - perf_branches increments on every FIFO pop whose kind was not illegal.
  - perf_mispredicts increments on every pop with mispredict set.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset but not by flush.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- beq, rs1 = rs2 = 5, pc = 0x1000, imm = 0x20, pc_pred = 0x1004, out_ready = 1 -> two cycles later out_valid = 1, pc_next = 0x1020, taken = 1, mispredict = 1, rd_data = 0.
- blt, rs1 = 0xFFFFFFFF, rs2 = 1, then bltu with the same operands; pc = 0x2000, pc_pred = 0x2004 -> first: taken = 1, pc_next = 0x2000 + imm; second: taken = 0, pc_next = 0x2004, mispredict = 0.
- JALR, rs1 = 0x3003, imm = 2, pc = 0x400, pc_pred = 0x3004 -> pc_next = 0x3004, rd_data = 0x404, mispredict = 0.
- out_ready = 0 with DEPTH = 4, streaming ops -> exactly 4 accepted, then in_ready = 0; raise out_ready -> results in order, tags match issue order, no loss or duplication.
- Fill FIFO with 3 ops, assert flush with in_valid = 1 -> next cycle out_valid = 0 and in_ready = 1; no flushed tag ever appears.
- BRU_PERF_CNT_EN defined, 10 ops with 3 mispredicts drained -> perf_branches = 10, perf_mispredicts = 3; after rst_n low for one edge, both read 0.
